wb_stage: RTL
=============

# wb_stage

Writeback stage of the five-stage pipeline: holds the MEM/WB pipeline register, selects ALU result or aligned/extended load data, and drives the register file write port. The register file commits writes on the falling clock edge, so a result presented here is readable by decode in the same cycle. Sits between the data-memory stage and the register file.

## Interface
- No parameters; widths are fixed (32-bit data, 5-bit register address).
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- WB_valid_in  in  1  MEM stage presents an instruction
- WB_ready_out  out  1  stage accepts this cycle; = !valid_q | !WB_stall
- WB_stall  in  1  hold current entry, suppress its write
- WB_flush  in  1  kill current entry at next edge
- WB_reg_write_in  in  1  instruction writes a register
- WB_mem_to_reg_in  in  1  1 = load data, 0 = ALU result
- WB_load_type_in  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- WB_rd_in  in  5  destination register
- WB_alu_result_in  in  32  ALU result / load address
- WB_mem_data_in  in  32  raw aligned word from data memory
- REG_write_1  out  1  register file write enable
- REG_address_wr  out  5  register file write address
- REG_data_wb_in1  out  32  register file write data
- WB_misalign_out  out  1  held load is misaligned; write suppressed
- WB_retire_count  out  32  retired-instruction count (WB_RETIRE_CNT_EN only)

## Operation
- Capture: posedge with WB_valid_in & WB_ready_out & !WB_flush loads all *_in fields, sets valid_q.
- Consume: entry leaves on posedge with valid_q & !WB_stall; valid_q clears unless a new capture occurs same edge.
- Write enable: REG_write_1 = valid_q & reg_write_q & (rd_q != 0) & !WB_stall & !misalign.
- Data select: mem_to_reg_q ? aligned load : alu_q.
- Load alignment, little-endian, offset = alu_q[1:0]: LB/LBU pick byte offset, sign/zero-extend; LH/LHU pick halfword offset[1], extend; LW takes word.
- Misalign: LH/LHU with offset[0]=1, LW with offset != 0; WB_misalign_out = valid_q & mem_to_reg_q & condition.
- Undefined load types (011, 110, 111) behave as LW.
- Flush: clears valid_q at next edge; current entry still writes this cycle (it is older than the flush source). Flush beats stall and new capture.
- Reset: rst_n low at posedge clears valid_q and all captured fields; REG_write_1, REG_address_wr, REG_data_wb_in1, WB_misalign_out = 0; WB_ready_out = 1.

## Timing
- Latency: one cycle from capture edge to REG_write_1 high; outputs are combinational from pipeline register.
- Write commits at the falling edge inside that cycle.
- Stall N cycles: REG_write_1 low for N cycles, high in the first unstalled cycle, entry consumed at its end.
- Back-to-back: one instruction per cycle when unstalled; capture and consume on same edge.
- rd = 0: entry consumed and counted, no write.

## Configuration
- WB_RETIRE_CNT_EN defined: 32-bit counter increments on every consume edge (including reg_write=0, rd=0, misaligned); wraps 0xFFFFFFFF -> 0; reset to 0; flush never decrements.
- Undefined: counter absent, WB_retire_count tied to 0.

## Structure
- Package wb_pkg: load-type constants LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU; DATA_W = 32, ADDR_W = 5.
- Sub-module wb_load_align: combinational (raw word, offset, type) -> extended data + misalign flag.

## Test plan
- LB at address 0x...3, mem 0x80FF_1234 -> REG_data_wb_in1 0xFFFF_FF80; LBU same -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF.
- ALU write rd=5 value 0xDEAD_BEEF, then rd=0 -> first writes r5 next cycle; second REG_write_1 stays 0, counter +2.
- Stall 3 cycles on held rd=7 entry -> REG_write_1 low 3 cycles, high fourth; WB_ready_out low during stall.
- Flush with WB_valid_in high -> new entry not captured; current entry still writes; valid_q 0 next cycle.
- LW at offset 1 -> WB_misalign_out 1, REG_write_1 0.
- rst_n low mid-stall -> all outputs 0, counter 0, WB_ready_out 1 next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and load-type encodings for the writeback stage.
package wb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB -> register-file signal bundle; master is the upstream/pipeline side.
interface wb_stage_if;
   import wb_pkg::*;

   logic              WB_valid_in;
   logic              WB_ready_out;
   logic              WB_stall;
   logic              WB_flush;
   logic              WB_reg_write_in;
   logic              WB_mem_to_reg_in;
   logic [2:0]        WB_load_type_in;
   logic [ADDR_W-1:0] WB_rd_in;
   logic [DATA_W-1:0] WB_alu_result_in;
   logic [DATA_W-1:0] WB_mem_data_in;
   logic              REG_write_1;
   logic [ADDR_W-1:0] REG_address_wr;
   logic [DATA_W-1:0] REG_data_wb_in1;
   logic              WB_misalign_out;
   logic [31:0]       WB_retire_count;

   modport master (
      output WB_valid_in, WB_stall, WB_flush, WB_reg_write_in, WB_mem_to_reg_in,
             WB_load_type_in, WB_rd_in, WB_alu_result_in, WB_mem_data_in,
      input  WB_ready_out, REG_write_1, REG_address_wr, REG_data_wb_in1,
             WB_misalign_out, WB_retire_count
   );

   modport slave (
      input  WB_valid_in, WB_stall, WB_flush, WB_reg_write_in, WB_mem_to_reg_in,
             WB_load_type_in, WB_rd_in, WB_alu_result_in, WB_mem_data_in,
      output WB_ready_out, REG_write_1, REG_address_wr, REG_data_wb_in1,
             WB_misalign_out, WB_retire_count
   );
endinterface

// File: rtl/wb_load_align.sv
// Little-endian load extraction and sign/zero extension with misalignment detect.
module wb_load_align
   import wb_pkg::*;
(
   input  logic [DATA_W-1:0] raw,
   input  logic [1:0]        offset,
   input  logic [2:0]        load_type,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? raw[31:16] : raw[15:0];
   end

   // Undefined encodings fall through to the word path, including its alignment rule.
   always_comb begin
      data     = raw;
      misalign = 1'b0;
      case (load_type)
         LT_LB: begin
            data = {{24{byte_sel[7]}}, byte_sel};
         end
         LT_LBU: begin
            data = {24'h0, byte_sel};
         end
         LT_LH: begin
            data     = {{16{half_sel[15]}}, half_sel};
            misalign = offset[0];
         end
         LT_LHU: begin
            data     = {16'h0, half_sel};
            misalign = offset[0];
         end
         default: begin
            data     = raw;
            misalign = (offset != 2'b00);
         end
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
   import wb_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   wb_stage_if.slave bus
);
   logic              valid_reg,     valid_next;
   logic              reg_write_reg, reg_write_next;
   logic              mem_to_reg_reg, mem_to_reg_next;
   logic [2:0]        load_type_reg, load_type_next;
   logic [ADDR_W-1:0] rd_reg,        rd_next;
   logic [DATA_W-1:0] alu_reg,       alu_next;
   logic [DATA_W-1:0] mem_reg,       mem_next;

   logic              ready;
   logic              capture;
   logic              consume;
   logic [DATA_W-1:0] load_data;
   logic              load_misalign;
   logic              misalign;

   assign ready   = !valid_reg || !bus.WB_stall;
   assign capture = bus.WB_valid_in && ready && !bus.WB_flush;
   assign consume = valid_reg && !bus.WB_stall;

   always_comb begin
      reg_write_next  = reg_write_reg;
      mem_to_reg_next = mem_to_reg_reg;
      load_type_next  = load_type_reg;
      rd_next         = rd_reg;
      alu_next        = alu_reg;
      mem_next        = mem_reg;
      if (capture) begin
         reg_write_next  = bus.WB_reg_write_in;
         mem_to_reg_next = bus.WB_mem_to_reg_in;
         load_type_next  = bus.WB_load_type_in;
         rd_next         = bus.WB_rd_in;
         alu_next        = bus.WB_alu_result_in;
         mem_next        = bus.WB_mem_data_in;
      end
   end

   // Flush wins over a same-edge capture; otherwise a capture refills a consumed slot.
   always_comb begin
      valid_next = valid_reg;
      if (bus.WB_flush)
         valid_next = 1'b0;
      else if (capture)
         valid_next = 1'b1;
      else if (consume)
         valid_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg      <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         load_type_reg  <= 3'b000;
         rd_reg         <= '0;
         alu_reg        <= '0;
         mem_reg        <= '0;
      end else begin
         valid_reg      <= valid_next;
         reg_write_reg  <= reg_write_next;
         mem_to_reg_reg <= mem_to_reg_next;
         load_type_reg  <= load_type_next;
         rd_reg         <= rd_next;
         alu_reg        <= alu_next;
         mem_reg        <= mem_next;
      end
   end

   wb_load_align u_align (
      .raw       (mem_reg),
      .offset    (alu_reg[1:0]),
      .load_type (load_type_reg),
      .data      (load_data),
      .misalign  (load_misalign)
   );

   assign misalign = valid_reg && mem_to_reg_reg && load_misalign;

   assign bus.WB_ready_out    = ready;
   assign bus.WB_misalign_out = misalign;
   assign bus.REG_write_1     = valid_reg && reg_write_reg && (rd_reg != '0)
                                && !bus.WB_stall && !misalign;
   assign bus.REG_address_wr  = rd_reg;
   assign bus.REG_data_wb_in1 = mem_to_reg_reg ? load_data : alu_reg;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_reg;

   always_ff @(posedge clk) begin
      if (!rst_n)
         retire_reg <= '0;
      else if (consume)
         retire_reg <= retire_reg + 32'd1;
   end

   assign bus.WB_retire_count = retire_reg;
`else
   assign bus.WB_retire_count = '0;
`endif
endmodule
